// File: rtl/transposer_egress_bridge.sv
// transposer_egress_bridge
//   Adapts the transposer core's valid-only output stream to a Decoupled
//   column interface. Beats are buffered in a small FIFO so that consumer
//   backpressure is honoured. The core receives an almost-full stall, and a
//   sticky overflow flag records any dropped beat.
// Ports
//   clock, reset                     rising-edge clock, async active-high reset
//   out_output_payload_discriminant  core beat valid (push request)
//   out_output_payload_Some_0_0      core beat, lane i at [i*ELEM_W +: ELEM_W]
//   core_stall                       count >= DEPTH-SKID
//   io_outCol_valid/ready/bits       Decoupled head-of-FIFO output
//   overflow                         sticky, set when a beat is dropped
//   occupancy                        current FIFO count (0..DEPTH)
module transposer_egress_bridge #(
    parameter int unsigned LANES  = 16,
    parameter int unsigned ELEM_W = 8,
    parameter int unsigned DEPTH  = 4,
    parameter int unsigned SKID   = 2
) (
    input  logic                       clock,
    input  logic                       reset,
    input  logic                       out_output_payload_discriminant,
    input  logic [LANES*ELEM_W-1:0]    out_output_payload_Some_0_0,
    output logic                       core_stall,
    output logic                       io_outCol_valid,
    output logic [LANES*ELEM_W-1:0]    io_outCol_bits,
    input  logic                       io_outCol_ready,
    output logic                       overflow,
    output logic [$clog2(DEPTH):0]     occupancy
);

    localparam int unsigned W  = LANES * ELEM_W;
    localparam int unsigned PW = $clog2(DEPTH);
    localparam int unsigned CW = PW + 1;

    logic [PW-1:0] wr_ptr_q, wr_ptr_d;
    logic [PW-1:0] rd_ptr_q, rd_ptr_d;
    logic [CW-1:0] count_q, count_d;
    logic          overflow_q, overflow_d;
    logic [W-1:0]  mem_q [DEPTH];
    logic [W-1:0]  mem_d [DEPTH];

    logic push, pop, full, empty, push_acc;

    always_comb begin
        empty    = (count_q == '0);
        full     = (count_q == CW'(DEPTH));
        push     = out_output_payload_discriminant;
        pop      = !empty && io_outCol_ready;
        // At full, a push still lands when the head leaves in the same cycle.
        push_acc = push && (!full || pop);
    end

    always_comb begin
        wr_ptr_d   = wr_ptr_q;
        rd_ptr_d   = rd_ptr_q;
        count_d    = count_q;
        overflow_d = overflow_q;
        mem_d      = mem_q;

        if (push_acc) begin
            mem_d[wr_ptr_q] = out_output_payload_Some_0_0;
            // DEPTH is a power of two, so the pointer wraps naturally.
            wr_ptr_d = wr_ptr_q + PW'(1);
        end
        if (pop) begin
            rd_ptr_d = rd_ptr_q + PW'(1);
        end
        if (push && !push_acc) begin
            overflow_d = 1'b1;
        end

        if (push_acc && !pop) begin
            count_d = count_q + CW'(1);
        end else if (!push_acc && pop) begin
            count_d = count_q - CW'(1);
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            count_q    <= '0;
            overflow_q <= 1'b0;
            for (int i = 0; i < int'(DEPTH); i++) begin
                mem_q[i] <= '0;
            end
        end else begin
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            count_q    <= count_d;
            overflow_q <= overflow_d;
            mem_q      <= mem_d;
        end
    end

    assign io_outCol_valid = !empty;
    assign io_outCol_bits  = mem_q[rd_ptr_q];
    assign core_stall      = (count_q >= CW'(DEPTH - SKID));
    assign overflow        = overflow_q;
    assign occupancy       = count_q;

endmodule

// File: tb/tb_transposer_egress_bridge.sv
// Testbench for transposer_egress_bridge: directed scenarios plus random
// traffic, checked by a negedge monitor against a queue-based model.
module tb_transposer_egress_bridge;

    localparam int LANES  = 16;
    localparam int ELEM_W = 8;
    localparam int DEPTH  = 4;
    localparam int SKID   = 2;
    localparam int W      = LANES * ELEM_W;

    logic          clock = 1'b0;
    logic          reset = 1'b1;
    logic          disc  = 1'b0;
    logic [W-1:0]  din   = '0;
    logic          ready = 1'b0;
    logic          core_stall, io_outCol_valid, overflow;
    logic [W-1:0]  io_outCol_bits;
    logic [$clog2(DEPTH):0] occupancy;

    transposer_egress_bridge #(
        .LANES (LANES),
        .ELEM_W(ELEM_W),
        .DEPTH (DEPTH),
        .SKID  (SKID)
    ) dut (
        .clock                          (clock),
        .reset                          (reset),
        .out_output_payload_discriminant(disc),
        .out_output_payload_Some_0_0    (din),
        .core_stall                     (core_stall),
        .io_outCol_valid                (io_outCol_valid),
        .io_outCol_bits                 (io_outCol_bits),
        .io_outCol_ready                (ready),
        .overflow                       (overflow),
        .occupancy                      (occupancy)
    );

    always #5 clock = ~clock;

    // Reference model: expected FIFO contents in order, plus sticky drop flag.
    logic [W-1:0] exp_q[$];
    logic         mdl_ovf = 1'b0;

    int checks   = 0;
    int failures = 0;

    task automatic chk(input string name, input logic [W-1:0] act, input logic [W-1:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, req, $time);
        end
    endtask

    function automatic logic [W-1:0] rnd_beat();
        logic [W-1:0] v;
        for (int i = 0; i < W / 32; i++) v[i*32 +: 32] = $urandom;
        return v;
    endfunction

    // Model step at a clock edge; the monitor has already removed a popped head
    // at the preceding negedge, so only occupancy before that pop matters here.
    int mdl_count = 0;
    task automatic model_edge(input logic p, input logic [W-1:0] d, input logic r);
        bit pp, acc;
        pp  = (mdl_count > 0) && r;
        acc = p && ((mdl_count < DEPTH) || pp);
        if (p && !acc) mdl_ovf = 1'b1;
        if (acc) exp_q.push_back(d);
        mdl_count = mdl_count + int'(acc) - int'(pp);
    endtask

    task automatic step(input logic p, input logic [W-1:0] d, input logic r);
        disc  = p;
        din   = d;
        ready = r;
        @(posedge clock);
        if (!reset) model_edge(p, d, r);
        #1;
    endtask

    task automatic model_clear();
        exp_q.delete();
        mdl_count = 0;
        mdl_ovf   = 1'b0;
    endtask

    // Monitor: compares status every negedge and the head beat when valid.
    initial begin
        forever begin
            @(negedge clock);
            chk("valid", W'(io_outCol_valid), W'(mdl_count > 0));
            chk("occupancy", W'(occupancy), W'(mdl_count));
            chk("core_stall", W'(core_stall), W'(mdl_count >= DEPTH - SKID));
            chk("overflow", W'(overflow), W'(mdl_ovf));
            if (reset) chk("bits_in_reset", io_outCol_bits, '0);
            if (io_outCol_valid) begin
                if (exp_q.size() == 0) begin
                    chk("head_underrun", io_outCol_bits, ~io_outCol_bits);
                end else begin
                    chk("head_bits", io_outCol_bits, exp_q[0]);
                    if (ready) void'(exp_q.pop_front());
                end
            end
        end
    end

    logic [W-1:0] beat_a, beat_b, beat_c, beat_d, beat_e, beat_f, beat_g, lane_ramp;

    initial begin
        for (int i = 0; i < LANES; i++) lane_ramp[i*ELEM_W +: ELEM_W] = ELEM_W'(i);
        beat_a = rnd_beat(); beat_b = rnd_beat(); beat_c = rnd_beat();
        beat_d = rnd_beat(); beat_e = rnd_beat(); beat_f = rnd_beat();
        beat_g = rnd_beat();

        // Reset held with discriminant asserted.
        reset = 1'b1;
        model_clear();
        repeat (3) step(1'b1, rnd_beat(), 1'b1);
        reset = 1'b0;
        step(1'b0, '0, 1'b0);

        // Single beat with consumer ready.
        step(1'b1, lane_ramp, 1'b1);
        chk("ramp_visible", io_outCol_bits, lane_ramp);
        step(1'b0, '0, 1'b1);
        step(1'b0, '0, 1'b1);

        // Backpressure: fill A..D, then drain.
        step(1'b1, beat_a, 1'b0);
        step(1'b1, beat_b, 1'b0);
        step(1'b1, beat_c, 1'b0);
        step(1'b1, beat_d, 1'b0);
        chk("fill_occ", W'(occupancy), W'(DEPTH));
        // Overflow: E dropped while full and stalled.
        step(1'b1, beat_e, 1'b0);
        chk("ovf_set", W'(overflow), W'(1));
        step(1'b0, '0, 1'b0);
        chk("head_is_a", io_outCol_bits, beat_a);
        // Full push+pop: A leaves, F lands, count holds.
        step(1'b1, beat_f, 1'b1);
        chk("full_pushpop_occ", W'(occupancy), W'(DEPTH));
        repeat (DEPTH + 1) step(1'b0, '0, 1'b1);

        // Wrap-around streaming at full over 3*DEPTH beats.
        repeat (DEPTH) step(1'b1, rnd_beat(), 1'b0);
        repeat (3 * DEPTH) step(1'b1, rnd_beat(), 1'b1);
        repeat (DEPTH + 1) step(1'b0, '0, 1'b1);

        // Mid-op reset with three entries resident.
        repeat (3) step(1'b1, rnd_beat(), 1'b0);
        reset = 1'b1;
        model_clear();
        #1;
        chk("reset_valid_now", W'(io_outCol_valid), W'(0));
        chk("reset_ovf_now", W'(overflow), W'(0));
        step(1'b0, '0, 1'b0);
        step(1'b0, '0, 1'b0);
        reset = 1'b0;
        step(1'b1, beat_g, 1'b0);
        chk("g_first", io_outCol_bits, beat_g);
        step(1'b0, '0, 1'b1);

        // Random traffic.
        for (int n = 0; n < 400; n++) begin
            step(1'($urandom_range(0, 99) < 60), rnd_beat(), 1'($urandom_range(0, 99) < 50));
        end
        repeat (DEPTH + 2) step(1'b0, '0, 1'b1);
        chk("drained", W'(exp_q.size()), W'(0));

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
